// File: rtl/kbd_tx.sv
// kbd_tx: PS/2 host-to-device command transmitter.
// Clock inhibit, request-to-send, device-clocked 11-bit frame, ACK check.
module kbd_tx #(
   parameter int INHIBIT = 3000,
   parameter int TIMEOUT = 500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps_clock,
   input  logic       ps_data,
   output logic       ps_clock_oe,
   output logic       ps_data_oe,
   input  logic       start,
   input  logic [7:0] din,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int CW = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
   localparam int TW = $clog2(TIMEOUT + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_XFER,
      S_ACK,
      S_WAITREL
   } state_t;

   state_t        state;
   logic [9:0]    sh;
   logic [CW-1:0] cnt;
   logic [3:0]    bitcnt;
   logic [TW-1:0] tmo;

   // [0],[1] synchronizer; [2] previous synced value for edge detect
   logic [2:0] clk_sync;
   logic [1:0] dat_sync;

   logic clk_fall;
   logic clk_edge;
   logic waiting;
   logic timed_out;

   always_ff @(posedge clock) begin
      if (reset) begin
         clk_sync <= 3'b111;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[1:0], ps_clock};
         dat_sync <= {dat_sync[0], ps_data};
      end
   end

   assign clk_fall  = (clk_sync[2:1] == 2'b10);
   assign clk_edge  = clk_sync[2] ^ clk_sync[1];
   assign waiting   = (state == S_XFER) || (state == S_ACK) ||
                      (state == S_WAITREL);
   assign timed_out = waiting && (tmo > TW'(TIMEOUT));

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         sh          <= '0;
         cnt         <= '0;
         bitcnt      <= '0;
         tmo         <= '0;
         ps_clock_oe <= 1'b0;
         ps_data_oe  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         if (waiting)
            tmo <= clk_edge ? '0 : tmo + 1'b1;
         if (timed_out) begin
            ps_clock_oe <= 1'b0;
            ps_data_oe  <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b1;
            state       <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !busy) begin
                     sh          <= {1'b1, ~^din, din};
                     busy        <= 1'b1;
                     ps_clock_oe <= 1'b1;
                     cnt         <= '0;
                     state       <= S_INHIBIT;
                  end
               end
               S_INHIBIT: begin
                  if (cnt == CW'(INHIBIT - 1)) begin
                     ps_data_oe <= 1'b1;
                     state      <= S_REQ;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_REQ: begin
                  ps_clock_oe <= 1'b0;
                  bitcnt      <= '0;
                  tmo         <= '0;
                  state       <= S_XFER;
               end
               S_XFER: begin
                  // edges 1..10 put din[0..7], parity, stop on the line
                  if (clk_fall) begin
                     ps_data_oe <= ~sh[0];
                     sh         <= {1'b0, sh[9:1]};
                     bitcnt     <= bitcnt + 1'b1;
                     if (bitcnt == 4'd9)
                        state <= S_ACK;
                  end
               end
               S_ACK: begin
                  if (clk_fall) begin
                     if (!dat_sync[1]) begin
                        state <= S_WAITREL;
                     end else begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end
                  end
               end
               S_WAITREL: begin
                  if (clk_sync[1] && dat_sync[1]) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_kbd_tx.sv
// tb_kbd_tx: scoreboard bench for kbd_tx with a PS/2 device model.
// Expected pulses are queued at start; a monitor pops them on done/error.
module tb_kbd_tx;

   localparam int HALF = 10;

   logic       clock;
   logic       reset;
   logic       start;
   logic [7:0] din;
   logic       ps_clock_oe;
   logic       ps_data_oe;
   logic       busy;
   logic       done;
   logic       error;
   logic       dev_clk_low;
   logic       dev_data_low;
   logic       ps_clock;
   logic       ps_data;

   // open-collector lines with pull-ups
   assign ps_clock = ~(ps_clock_oe | dev_clk_low);
   assign ps_data  = ~(ps_data_oe | dev_data_low);

   kbd_tx #(
      .INHIBIT(8),
      .TIMEOUT(400)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .ps_clock   (ps_clock),
      .ps_data    (ps_data),
      .ps_clock_oe(ps_clock_oe),
      .ps_data_oe (ps_data_oe),
      .start      (start),
      .din        (din),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       dn;
      logic       er;
      logic       cf;
      logic [9:0] fr;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       e_cur;
   logic [9:0] rx_frame;
   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && (done || error)) begin
         if (exp_q.size() == 0) begin
            chk("spurious_pulse", {30'd0, done, error}, 32'd0);
         end else begin
            e_cur = exp_q.pop_front();
            chk("done", done, e_cur.dn);
            chk("error", error, e_cur.er);
            if (e_cur.cf)
               chk("frame", rx_frame, e_cur.fr);
            chk("busy_in_pulse", busy, 1'b0);
            chk("oe_in_pulse", {ps_clock_oe, ps_data_oe}, 2'b00);
         end
         pulses++;
      end
   end

   task automatic send(input logic [7:0] d);
      @(negedge clock);
      start = 1'b1;
      din   = d;
      @(posedge clock);
      #1;
      start = 1'b0;
      din   = 8'hAA;
   endtask

   // device: clocks 10 bits in (sample on rising), then optional ACK
   task automatic dev_frame(input bit ack, input int stop_after,
                            output bit ok);
      int w;
      ok       = 1'b0;
      rx_frame = '0;
      w        = 0;
      while (!(ps_clock === 1'b1 && ps_data === 1'b0) && w < 200) begin
         @(negedge clock);
         w++;
      end
      if (w >= 200)
         return;
      for (int i = 0; i < 10; i++) begin
         if (i == stop_after) begin
            ok = 1'b1;
            return;
         end
         repeat (HALF) @(negedge clock);
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clock);
         dev_clk_low = 1'b0;
         rx_frame[i] = ps_data;
      end
      repeat (HALF) @(negedge clock);
      if (ack)
         dev_data_low = 1'b1;
      repeat (4) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (4) @(negedge clock);
      dev_data_low = 1'b0;
      ok = 1'b1;
   endtask

   task automatic wait_pulses(input string nm, input int target,
                              input int bound, output int n);
      n = 0;
      while (pulses < target && n < bound) begin
         @(negedge clock);
         n++;
      end
      chk(nm, pulses, target);
   endtask

   initial begin
      int n;
      bit ok;
      reset        = 1'b1;
      start        = 1'b0;
      din          = 8'h00;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_outputs",
          {ps_clock_oe, ps_data_oe, busy, done, error}, 5'b0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);

      // T1: 0xED with inhibit / request ordering
      exp_q.push_back('{dn: 1'b1, er: 1'b0, cf: 1'b1, fr: 10'h3ED});
      send(8'hED);
      chk("t1_busy", busy, 1'b1);
      chk("t1_inhibit_start", {ps_clock_oe, ps_data_oe}, 2'b10);
      n = 0;
      while (!ps_data_oe && n < 50) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("t1_inhibit_cycles", n, 8);
      chk("t1_clk_held_at_request", ps_clock_oe, 1'b1);
      @(posedge clock);
      #1;
      chk("t1_clk_release", {ps_clock_oe, ps_data_oe}, 2'b01);
      dev_frame(1'b1, 99, ok);
      chk("t1_request_seen", ok, 1'b1);
      wait_pulses("t1_pulse", 1, 500, n);
      repeat (5) @(negedge clock);

      // T2: parity of 0x00 and 0x01
      exp_q.push_back('{dn: 1'b1, er: 1'b0, cf: 1'b1, fr: 10'h300});
      send(8'h00);
      dev_frame(1'b1, 99, ok);
      chk("t2a_request_seen", ok, 1'b1);
      wait_pulses("t2a_pulse", 2, 500, n);
      repeat (5) @(negedge clock);
      exp_q.push_back('{dn: 1'b1, er: 1'b0, cf: 1'b1, fr: 10'h201});
      send(8'h01);
      dev_frame(1'b1, 99, ok);
      chk("t2b_request_seen", ok, 1'b1);
      wait_pulses("t2b_pulse", 3, 500, n);
      repeat (5) @(negedge clock);

      // T3: silent device -> timeout
      exp_q.push_back('{dn: 1'b0, er: 1'b1, cf: 1'b0, fr: 10'h000});
      send(8'h12);
      wait_pulses("t3_pulse", 4, 1000, n);
      chk("t3_latency_window", (n >= 400 && n <= 460), 1'b1);
      repeat (5) @(negedge clock);

      // T4: missing ACK
      exp_q.push_back('{dn: 1'b0, er: 1'b1, cf: 1'b1, fr: 10'h30F});
      send(8'h0F);
      dev_frame(1'b0, 99, ok);
      chk("t4_request_seen", ok, 1'b1);
      wait_pulses("t4_pulse", 5, 500, n);
      repeat (5) @(negedge clock);

      // T5: reset after bit 4, then a clean 0xFF
      send(8'hC3);
      dev_frame(1'b1, 4, ok);
      chk("t5_request_seen", ok, 1'b1);
      chk("t5_busy_mid_frame", busy, 1'b1);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("t5_reset_release",
          {ps_clock_oe, ps_data_oe, busy, done, error}, 5'b0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      exp_q.push_back('{dn: 1'b1, er: 1'b0, cf: 1'b1, fr: 10'h3FF});
      send(8'hFF);
      dev_frame(1'b1, 99, ok);
      chk("t5_request_seen_2", ok, 1'b1);
      wait_pulses("t5_pulse", 6, 500, n);
      repeat (5) @(negedge clock);

      // T6: start while busy is dropped
      exp_q.push_back('{dn: 1'b1, er: 1'b0, cf: 1'b1, fr: 10'h33C});
      send(8'h3C);
      repeat (2) @(negedge clock);
      start = 1'b1;
      din   = 8'h55;
      @(negedge clock);
      start = 1'b0;
      chk("t6_busy_held", busy, 1'b1);
      dev_frame(1'b1, 99, ok);
      chk("t6_request_seen", ok, 1'b1);
      wait_pulses("t6_pulse", 7, 500, n);
      repeat (30) @(negedge clock);
      chk("t6_no_second_frame", {busy, ps_clock_oe}, 2'b00);
      chk("t6_no_extra_pulse", pulses, 7);

      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
